clock_text_renderer: RTL and testbench

- Pixel-domain stage directly upstream of the glyph font ROM. Drives its bank select, glyph index and row, then consumes the returned 8-bit row.
- Renders a 10-cell text field "HH:MM:SS" + blank + ring glyph at a fixed screen origin.
- Outputs a 12-bit RGB pixel aligned to the VGA pixel pipeline.
- BCD time and alarm state are latched once per frame to prevent tearing; the ring glyph blinks at a frame-count rate.

---
 rtl/clock_text_renderer_pkg.sv | 58 +++++
 rtl/clock_text_renderer_if.sv | 28 ++
 rtl/clock_text_renderer_glyph_mapper.sv | 53 +++++
 rtl/clock_text_renderer.sv | 171 +++++++++++++++++
 tb/tb_clock_text_renderer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_text_renderer_pkg.sv
// ----------------------------------------------------------------------------
// clock_text_renderer_pkg
// Shared constants and types for the clock text renderer. It holds the font
// ROM bank/glyph numbering, the text-cell geometry, the cell layout enum and
// a helper that maps a BCD nibble to its font bank and glyph index.
// ----------------------------------------------------------------------------
package clock_text_renderer_pkg;

    // Font ROM banks. Each bank holds four glyphs.
    localparam logic [3:0] FONT_BANK_BLANK = 4'd0;   // ROM returns all-zero rows
    localparam logic [3:0] FONT_BANK_DIG0  = 4'd4;   // digits 0..3
    localparam logic [3:0] FONT_BANK_DIG4  = 4'd5;   // digits 4..7
    localparam logic [3:0] FONT_BANK_MISC  = 4'd6;   // 8, 9, colon, ring

    localparam logic [1:0] GLYPH_COLON = 2'd2;
    localparam logic [1:0] GLYPH_RING  = 2'd3;

    localparam int CELL_W = 8;
    localparam int CELL_H = 16;
    localparam int NCELLS = 10;

    // Layout of the text field "HH:MM:SS" + blank + ring.
    typedef enum logic [3:0] {
        CELL_H1   = 4'd0,
        CELL_H0   = 4'd1,
        CELL_C0   = 4'd2,
        CELL_M1   = 4'd3,
        CELL_M0   = 4'd4,
        CELL_C1   = 4'd5,
        CELL_S1   = 4'd6,
        CELL_S0   = 4'd7,
        CELL_SP   = 4'd8,
        CELL_RING = 4'd9
    } cell_e;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] ad;
    } glyph_t;

    localparam glyph_t GLYPH_BLANK = '{sel: FONT_BANK_BLANK, ad: 2'd0};

    // Digit d lives in bank 4 + d/4 at index d%4; non-decimal nibbles blank.
    function automatic glyph_t digit_glyph(input logic [3:0] d);
        glyph_t g;
        g = GLYPH_BLANK;
        if (d <= 4'd9) begin
            case (d[3:2])
                2'd0:    g.sel = FONT_BANK_DIG0;
                2'd1:    g.sel = FONT_BANK_DIG4;
                default: g.sel = FONT_BANK_MISC;
            endcase
            g.ad = d[1:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/clock_text_renderer_if.sv
// ----------------------------------------------------------------------------
// clock_text_renderer_if
// Font ROM bus between the renderer (master) and the glyph font ROM (slave).
//   font_sel  : ROM bank select (0 = blank bank)
//   font_ad   : glyph index within the bank
//   font_row  : glyph row 0..15
//   font_data : ROM row, combinational from the three above; bit7 = leftmost
// ----------------------------------------------------------------------------
interface clock_text_renderer_if;
    logic [3:0] font_sel;
    logic [1:0] font_ad;
    logic [3:0] font_row;
    logic [7:0] font_data;

    modport master (
        output font_sel,
        output font_ad,
        output font_row,
        input  font_data
    );

    modport slave (
        input  font_sel,
        input  font_ad,
        input  font_row,
        output font_data
    );
endinterface

// File: rtl/clock_text_renderer_glyph_mapper.sv
// ----------------------------------------------------------------------------
// clock_text_renderer_glyph_mapper
// Combinational map from a text-cell index to the font glyph it shows.
//   cell_i      : cell index 0..9 within the field
//   hr_i/min_i/sec_i : latched BCD time, two nibbles each
//   ring_show_i : ring glyph visible (alarm latched and blink phase on)
//   in_field_i  : current pixel lies inside the text field
//   glyph_o     : {bank select, glyph index}; blank outside the field
// ----------------------------------------------------------------------------
module clock_text_renderer_glyph_mapper
    import clock_text_renderer_pkg::*;
(
    input  logic [3:0] cell_i,
    input  logic [7:0] hr_i,
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    input  logic       ring_show_i,
    input  logic       in_field_i,
    output glyph_t     glyph_o
);

    logic [23:0] bcd_all;
    glyph_t      dig [6];

    // Digit order H1 H0 M1 M0 S1 S0, most significant nibble first.
    assign bcd_all = {hr_i, min_i, sec_i};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign dig[gi] = digit_glyph(bcd_all[23 - 4*gi -: 4]);
        end
    endgenerate

    always_comb begin
        glyph_o = GLYPH_BLANK;
        if (in_field_i) begin
            case (cell_e'(cell_i))
                CELL_H1:   glyph_o = dig[0];
                CELL_H0:   glyph_o = dig[1];
                CELL_M1:   glyph_o = dig[2];
                CELL_M0:   glyph_o = dig[3];
                CELL_S1:   glyph_o = dig[4];
                CELL_S0:   glyph_o = dig[5];
                CELL_C0,
                CELL_C1:   glyph_o = '{sel: FONT_BANK_MISC, ad: GLYPH_COLON};
                CELL_RING: if (ring_show_i) glyph_o = '{sel: FONT_BANK_MISC, ad: GLYPH_RING};
                default:   glyph_o = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/clock_text_renderer.sv
// ----------------------------------------------------------------------------
// clock_text_renderer
// Renders "HH:MM:SS" + blank + blinking alarm ring as a 10-cell text field at
// (X0, Y0), magnified by 2^SCALE_LOG2, driving the glyph font ROM and
// producing a 12-bit RGB pixel two pixel_ticks after the pixel coordinate.
//   clk, reset         : clock, synchronous active-high reset
//   pixel_tick         : pixel enable; every register advances only when high
//   video_on           : active video for pixel_x/pixel_y
//   pixel_x, pixel_y   : current pixel coordinate
//   hr/min/sec_bcd     : BCD time, sampled once per frame at pixel (0,0)
//   ring               : alarm active, sampled with the time
//   font_bus           : font ROM bus (sel/ad/row out, row data in)
//   rgb                : pixel colour
//   text_on            : output pixel is a lit glyph pixel
// ----------------------------------------------------------------------------
module clock_text_renderer
    import clock_text_renderer_pkg::*;
#(
    parameter int          X0           = 16,
    parameter int          Y0           = 32,
    parameter int          SCALE_LOG2   = 0,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pixel_tick,
    input  logic                         video_on,
    input  logic [9:0]                   pixel_x,
    input  logic [9:0]                   pixel_y,
    input  logic [7:0]                   hr_bcd,
    input  logic [7:0]                   min_bcd,
    input  logic [7:0]                   sec_bcd,
    input  logic                         ring,
    clock_text_renderer_if.master        font_bus,
    output logic [11:0]                  rgb,
    output logic                         text_on
);

    localparam int              CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]      X0_L    = 10'(X0);
    localparam logic [9:0]      Y0_L    = 10'(Y0);
    localparam logic [10:0]     FIELD_W = 11'(NCELLS * CELL_W) << SCALE_LOG2;
    localparam logic [10:0]     FIELD_H = 11'(CELL_H) << SCALE_LOG2;

    // ---------------- frame latch and blink counter ----------------
    logic [7:0]       hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic             ring_q, ring_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             latch_now;

    assign latch_now = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    always_comb begin
        hr_d          = hr_q;
        min_d         = min_q;
        sec_d         = sec_q;
        ring_d        = ring_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (latch_now) begin
            hr_d   = hr_bcd;
            min_d  = min_bcd;
            sec_d  = sec_bcd;
            ring_d = ring;
            if (ring) begin
                if (blink_cnt_q == CNT_MAX) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end else begin
                // Alarm off: restart so the ring appears at once when it rises.
                blink_cnt_d   = '0;
                blink_phase_d = 1'b1;
            end
        end
    end

    // ---------------- geometry ----------------
    logic [9:0] rel_x, rel_y;
    logic [6:0] cx;
    logic [3:0] glyph_row;
    logic       in_field;

    assign rel_x     = pixel_x - X0_L;
    assign rel_y     = pixel_y - Y0_L;
    assign in_field  = (pixel_x >= X0_L) && (pixel_y >= Y0_L) &&
                       ({1'b0, rel_x} < FIELD_W) && ({1'b0, rel_y} < FIELD_H);
    // Only the low bits matter once in_field has bounded the coordinates.
    assign cx        = 7'(rel_x >> SCALE_LOG2);
    assign glyph_row = 4'(rel_y >> SCALE_LOG2);

    // The mapper sees the _d values so the latch pixel uses the fresh capture.
    glyph_t glyph;

    clock_text_renderer_glyph_mapper u_glyph_mapper (
        .cell_i      (cx[6:3]),
        .hr_i        (hr_d),
        .min_i       (min_d),
        .sec_i       (sec_d),
        .ring_show_i (ring_d & blink_phase_d),
        .in_field_i  (in_field),
        .glyph_o     (glyph)
    );

    // ---------------- stage 0: font address ----------------
    logic [3:0] s0_sel_q, s0_row_q;
    logic [1:0] s0_ad_q;
    logic [2:0] s0_bit_q;
    logic       s0_in_field_q, s0_video_on_q;

    assign font_bus.font_sel = s0_sel_q;
    assign font_bus.font_ad  = s0_ad_q;
    assign font_bus.font_row = s0_row_q;

    // ---------------- stage 1: pixel colour ----------------
    logic        lit;
    logic [11:0] rgb_q, rgb_d;
    logic        text_on_q, text_on_d;

    assign lit = s0_in_field_q & font_bus.font_data[3'd7 - s0_bit_q];

    always_comb begin
        text_on_d = lit;
        rgb_d     = 12'h000;
        if (s0_video_on_q) rgb_d = lit ? FG_COLOR : BG_COLOR;
    end

    assign rgb     = rgb_q;
    assign text_on = text_on_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hr_q          <= 8'hFF;
            min_q         <= 8'hFF;
            sec_q         <= 8'hFF;
            ring_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            s0_sel_q      <= 4'd0;
            s0_ad_q       <= 2'd0;
            s0_row_q      <= 4'd0;
            s0_bit_q      <= 3'd0;
            s0_in_field_q <= 1'b0;
            s0_video_on_q <= 1'b0;
            rgb_q         <= 12'h000;
            text_on_q     <= 1'b0;
        end else if (pixel_tick) begin
            hr_q          <= hr_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            ring_q        <= ring_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            s0_sel_q      <= glyph.sel;
            s0_ad_q       <= glyph.ad;
            s0_row_q      <= glyph_row;
            s0_bit_q      <= cx[2:0];
            s0_in_field_q <= in_field;
            s0_video_on_q <= video_on;
            rgb_q         <= rgb_d;
            text_on_q     <= text_on_d;
        end
    end

endmodule

// File: tb/tb_clock_text_renderer.sv
`timescale 1ns/1ps
module tb_clock_text_renderer;
    import clock_text_renderer_pkg::*;

    logic       clk = 1'b0;
    logic       reset, pixel_tick, video_on, ring;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] hr_bcd, min_bcd, sec_bcd;
    logic [11:0] rgb0, rgb1;
    logic        text_on0, text_on1;

    always #5 clk = ~clk;

    // Bench font ROM: colon has a known two-pixel pattern on rows 5 and 10,
    // other glyphs get a fixed scrambled pattern, bank 0 is blank.
    function automatic logic [7:0] rom_row(input logic [3:0] sel, input logic [1:0] ad,
                                           input logic [3:0] row);
        if (sel == 4'd0) return 8'h00;
        if (sel == 4'd6 && ad == 2'd2) return (row == 4'd5 || row == 4'd10) ? 8'h30 : 8'h00;
        return {row, ad, sel[1:0]} ^ 8'h96;
    endfunction

    clock_text_renderer_if bus0();
    clock_text_renderer_if bus1();
    assign bus0.font_data = rom_row(bus0.font_sel, bus0.font_ad, bus0.font_row);
    assign bus1.font_data = rom_row(bus1.font_sel, bus1.font_ad, bus1.font_row);

    clock_text_renderer #(.X0(16), .Y0(32), .SCALE_LOG2(0), .BLINK_FRAMES(2),
                          .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)) dut0 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hr_bcd(hr_bcd), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .ring(ring), .font_bus(bus0), .rgb(rgb0), .text_on(text_on0));

    clock_text_renderer #(.X0(16), .Y0(32), .SCALE_LOG2(1), .BLINK_FRAMES(2),
                          .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)) dut1 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hr_bcd(hr_bcd), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .ring(ring), .font_bus(bus1), .rgb(rgb1), .text_on(text_on1));

    // ---------------- scoreboard ----------------
    typedef struct { int due; int id; int mode; logic [3:0] sel; logic [1:0] ad; logic [3:0] row; } font_exp_t;
    typedef struct { int due; int id; logic [11:0] rgb; logic text_on; } pix_exp_t;

    font_exp_t font_q[$];
    pix_exp_t  pix_q[$];
    font_exp_t fe_m;
    pix_exp_t  pe_m;
    int  tick_cnt = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_ticked;

    task automatic check_font(input font_exp_t e);
        logic [3:0] s, r;
        logic [1:0] a;
        bit bad;
        if (e.id == 0) begin s = bus0.font_sel; a = bus0.font_ad; r = bus0.font_row; end
        else           begin s = bus1.font_sel; a = bus1.font_ad; r = bus1.font_row; end
        bad = (s != e.sel) || (e.mode == 2 && (a != e.ad || r != e.row));
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL font dut%0d tick %0d: got sel=%0d ad=%0d row=%0d, want sel=%0d ad=%0d row=%0d",
                     e.id, tick_cnt, s, a, r, e.sel, e.ad, e.row);
        end
    endtask

    task automatic check_pix(input pix_exp_t e);
        logic [11:0] c;
        logic        t;
        if (e.id == 0) begin c = rgb0; t = text_on0; end
        else           begin c = rgb1; t = text_on1; end
        n_checks++;
        if (c != e.rgb || t != e.text_on) begin
            n_fail++;
            $display("FAIL pixel dut%0d tick %0d: got rgb=%h text_on=%0b, want rgb=%h text_on=%0b",
                     e.id, tick_cnt, c, t, e.rgb, e.text_on);
        end else begin
            $display("tick %0d dut%0d rgb=%h text_on=%0b ok", tick_cnt, e.id, c, t);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: after every pixel_tick edge, compare whatever is due now.
    always @(posedge clk) begin
        mon_ticked = pixel_tick && !reset;
        #2;
        if (mon_ticked) begin
            tick_cnt++;
            while (font_q.size() > 0 && font_q[0].due <= tick_cnt) begin
                fe_m = font_q.pop_front();
                check_font(fe_m);
            end
            while (pix_q.size() > 0 && pix_q[0].due <= tick_cnt) begin
                pe_m = pix_q.pop_front();
                check_pix(pe_m);
            end
        end
    end

    // ---------------- stimulus ----------------
    // fmode: 0 = no font check, 1 = bank select only, 2 = sel/ad/row.
    task automatic drive(input int id, input logic [9:0] x, input logic [9:0] y, input logic vid,
                         input int fmode, input logic [3:0] esel, input logic [1:0] ead,
                         input logic [3:0] erow, input logic [2:0] ebit, input logic ein);
        font_exp_t fe;
        pix_exp_t  pe;
        logic [7:0] rr;
        logic       lit;
        @(negedge clk);
        pixel_tick = 1'b1;
        pixel_x    = x;
        pixel_y    = y;
        video_on   = vid;
        if (fmode != 0) begin
            fe.due = tick_cnt + 1; fe.id = id; fe.mode = fmode;
            fe.sel = esel; fe.ad = ead; fe.row = erow;
            font_q.push_back(fe);
        end
        rr  = rom_row(esel, ead, erow);
        lit = ein & rr[3'd7 - ebit];
        pe.due = tick_cnt + 2; pe.id = id; pe.text_on = lit;
        pe.rgb = vid ? (lit ? 12'hFFF : 12'h000) : 12'h000;
        pix_q.push_back(pe);
        @(posedge clk);
    endtask

    task automatic scan(input int id, input int x0, input int y, input int n, input int sh,
                        input int fmode, input logic [3:0] sel, input logic [1:0] ad,
                        input logic [3:0] row);
        for (int i = 0; i < n; i++)
            drive(id, 10'(x0 + i), 10'(y), 1'b1, fmode, sel, ad, row, 3'(i >> sh), 1'b1);
    endtask

    task automatic latch(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic r);
        hr_bcd = h; min_bcd = m; sec_bcd = s; ring = r;
        drive(0, 10'd0, 10'd0, 1'b0, 1, 4'd0, 2'd0, 4'd0, 3'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0; ring = 1'b0;
        pixel_x = '0; pixel_y = '0; hr_bcd = '0; min_bcd = '0; sec_bcd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset rgb",      int'(rgb0), 0);
        check_eq("reset text_on",  int'(text_on0), 0);
        check_eq("reset font_sel", int'(bus0.font_sel), 0);
        check_eq("reset font_ad",  int'(bus0.font_ad), 0);
        check_eq("reset font_row", int'(bus0.font_row), 0);
        check_eq("reset rgb dut1", int'(rgb1), 0);
        reset = 1'b0;

        // Latched digits are FF after reset: the H1 cell is blank.
        scan(0, 16, 33, 8, 0, 1, 4'd0, 2'd0, 4'd0);

        // Time 12:34:56, alarm off.
        latch(8'h12, 8'h34, 8'h56, 1'b0);
        drive(0, 10'd16, 10'd33, 1'b1, 2, 4'd4, 2'd1, 4'd1, 3'd0, 1'b1);
        scan(0, 16, 33, 8, 0, 2, 4'd4, 2'd1, 4'd1);            // H1 = 1
        scan(0, 32, 37, 8, 0, 2, 4'd6, 2'd2, 4'd5);            // colon, lit at x=34,35
        scan(0, 40, 37, 8, 0, 2, 4'd4, 2'd3, 4'd5);            // M1 = 3
        scan(0, 72, 37, 8, 0, 2, 4'd5, 2'd2, 4'd5);            // S0 = 6
        scan(0, 80, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);            // blank cell
        scan(0, 88, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);            // ring off
        drive(0, 10'd34, 10'd37, 1'b0, 2, 4'd6, 2'd2, 4'd5, 3'd2, 1'b1); // lit, blanked video
        drive(0, 10'd15, 10'd37, 1'b1, 1, 4'd0, 2'd0, 4'd0, 3'd0, 1'b0); // left of field
        drive(0, 10'd96, 10'd37, 1'b1, 1, 4'd0, 2'd0, 4'd0, 3'd0, 1'b0); // right of field
        drive(0, 10'd16, 10'd31, 1'b1, 1, 4'd0, 2'd0, 4'd0, 3'd0, 1'b0); // above field
        drive(0, 10'd16, 10'd48, 1'b1, 1, 4'd0, 2'd0, 4'd0, 3'd0, 1'b0); // below field
        drive(0, 10'd95, 10'd47, 1'b1, 2, 4'd0, 2'd0, 4'd15, 3'd7, 1'b1); // last field pixel

        // Non-decimal minute tens and a 9 in seconds units.
        latch(8'h12, 8'hA4, 8'h59, 1'b0);
        scan(0, 40, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);
        scan(0, 72, 37, 8, 0, 2, 4'd6, 2'd1, 4'd5);

        // Ring blink with two frames per half period: shown, hidden, hidden, shown.
        latch(8'h12, 8'h34, 8'h56, 1'b1);
        scan(0, 88, 37, 8, 0, 2, 4'd6, 2'd3, 4'd5);
        latch(8'h12, 8'h34, 8'h56, 1'b1);
        scan(0, 88, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);
        latch(8'h12, 8'h34, 8'h56, 1'b1);
        scan(0, 88, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);
        latch(8'h12, 8'h34, 8'h56, 1'b1);
        scan(0, 88, 37, 8, 0, 2, 4'd6, 2'd3, 4'd5);
        latch(8'h12, 8'h34, 8'h56, 1'b0);
        scan(0, 88, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);
        latch(8'h12, 8'h34, 8'h56, 1'b1);                       // restart: shown again
        scan(0, 88, 37, 8, 0, 2, 4'd6, 2'd3, 4'd5);

        // pixel_tick low holds every register.
        drive(0, 10'd34, 10'd37, 1'b1, 2, 4'd6, 2'd2, 4'd5, 3'd2, 1'b1);
        drive(0, 10'd35, 10'd37, 1'b1, 2, 4'd6, 2'd2, 4'd5, 3'd3, 1'b1);
        @(negedge clk);
        pixel_tick = 1'b0;
        pixel_x = 10'd200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold rgb",      int'(rgb0), 'hFFF);
            check_eq("hold text_on",  int'(text_on0), 1);
            check_eq("hold font_sel", int'(bus0.font_sel), 6);
            check_eq("hold font_ad",  int'(bus0.font_ad), 2);
            check_eq("hold font_row", int'(bus0.font_row), 5);
        end

        // Double-size instance: each glyph bit covers 2 pixels and 2 rows.
        scan(1, 16, 34, 16, 1, 2, 4'd4, 2'd1, 4'd1);
        scan(1, 16, 35, 16, 1, 2, 4'd4, 2'd1, 4'd1);
        scan(1, 32, 34, 16, 1, 2, 4'd4, 2'd2, 4'd1);           // H0 = 2

        // Reset in the middle of the field.
        scan(0, 40, 37, 8, 0, 2, 4'd4, 2'd3, 4'd5);
        drive(0, 10'd48, 10'd37, 1'b1, 2, 4'd5, 2'd0, 4'd5, 3'd0, 1'b1);
        drive(0, 10'd49, 10'd37, 1'b1, 2, 4'd5, 2'd0, 4'd5, 3'd1, 1'b1);
        @(negedge clk);
        font_q.delete();
        pix_q.delete();
        reset = 1'b1; pixel_tick = 1'b1; pixel_x = 10'd50; pixel_y = 10'd37; video_on = 1'b1;
        @(negedge clk);
        check_eq("midreset rgb",      int'(rgb0), 0);
        check_eq("midreset text_on",  int'(text_on0), 0);
        check_eq("midreset font_sel", int'(bus0.font_sel), 0);
        check_eq("midreset rgb dut1", int'(rgb1), 0);
        reset = 1'b0; pixel_tick = 1'b0;
        scan(0, 16, 33, 8, 0, 1, 4'd0, 2'd0, 4'd0);            // digits blank again
        scan(0, 40, 37, 8, 0, 1, 4'd0, 2'd0, 4'd0);
        latch(8'h12, 8'h34, 8'h56, 1'b0);
        scan(0, 16, 33, 8, 0, 2, 4'd4, 2'd1, 4'd1);
        scan(0, 40, 37, 8, 0, 2, 4'd4, 2'd3, 4'd5);

        // Flush the pipeline so every queued expectation is compared.
        @(negedge clk);
        pixel_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd600; video_on = 1'b0;
        repeat (3) @(negedge clk);
        pixel_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("font queue drained",  font_q.size(), 0);
        check_eq("pixel queue drained", pix_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
